// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file peripheral: oversampled pins, framed writes with commit on
// chip-select release, register read-back on cipo, write strobe and frame-length error pulse.
module spi_regfile_peripheral #(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ncs,
    input  logic                       sclk,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME + 2);
    localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME + 1);
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  CNT_HDR   = CNT_W'(1 + ADDR_W);
    localparam logic [ADDR_W:0]   NREGS     = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Synchronisers; the top flop of ncs/sclk is the delayed copy for edge detection.
    logic [SYNC_STAGES:0]   ncs_sr, sclk_sr;
    logic [SYNC_STAGES-1:0] copi_sr;
    logic ncs_s, ncs_d, sclk_s, sclk_d, copi_s;
    logic ncs_fall, ncs_rise, sclk_rise, sclk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sr  <= '1;
            sclk_sr <= '0;
            copi_sr <= '0;
        end else begin
            ncs_sr  <= {ncs_sr[SYNC_STAGES-1:0], ncs};
            sclk_sr <= {sclk_sr[SYNC_STAGES-1:0], sclk};
            copi_sr <= {copi_sr[SYNC_STAGES-2:0], copi};
        end
    end

    assign ncs_s     = ncs_sr[SYNC_STAGES-1];
    assign ncs_d     = ncs_sr[SYNC_STAGES];
    assign sclk_s    = sclk_sr[SYNC_STAGES-1];
    assign sclk_d    = sclk_sr[SYNC_STAGES];
    assign copi_s    = copi_sr[SYNC_STAGES-1];
    assign ncs_fall  = ncs_d & ~ncs_s;
    assign ncs_rise  = ~ncs_d & ncs_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    state_t state, state_n;
    logic [CNT_W-1:0]  bit_cnt;
    logic [FRAME-1:0]  rx, rx_next;
    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [DATA_W-1:0] tx_shift, rd_val;
    logic              f_rw;
    logic [ADDR_W-1:0] f_addr, hdr_addr;
    logic [DATA_W-1:0] f_data;
    logic              f_in_range;
    logic              shift_en, commit, hdr_done, load_rd, do_write, do_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // A back-to-back frame may start while the previous one is still committing.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (ncs_fall) state_n = SHIFT;
            SHIFT:   if (ncs_rise) state_n = DONE;
            DONE:    state_n = ncs_fall ? SHIFT : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // An sclk rise coinciding with the ncs rise is dropped.
    always_comb begin
        shift_en = 1'b0;
        commit   = 1'b0;
        case (state)
            SHIFT:   shift_en = sclk_rise & ~ncs_rise;
            DONE:    commit   = 1'b1;
            default: ;
        endcase
    end

    assign rx_next    = {rx[FRAME-2:0], copi_s};
    assign f_rw       = rx[FRAME-1];
    assign f_addr     = rx[FRAME-2 -: ADDR_W];
    assign f_data     = rx[DATA_W-1:0];
    assign f_in_range = {1'b0, f_addr} < NREGS;
    assign do_write   = commit && bit_cnt == CNT_FRAME && f_rw && f_in_range;
    assign do_err     = commit && bit_cnt != CNT_FRAME && bit_cnt != '0;

    // Header is complete on the rise that brings in the last address bit.
    assign hdr_done = shift_en && bit_cnt == CNT_PRE;
    assign hdr_addr = rx_next[ADDR_W-1:0];
    assign load_rd  = hdr_done && !rx_next[ADDR_W];

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (hdr_addr == ADDR_W'(i)) rd_val = mem[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            rx      <= '0;
        end else if (ncs_fall) begin
            bit_cnt <= '0;
            rx      <= '0;
        end else if (shift_en) begin
            rx <= rx_next;
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // The first data bit is sampled by the controller before any shift, so
    // shifting starts only on falls after that bit's rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '0;
            cipo_oe  <= 1'b0;
        end else if (ncs_rise || ncs_fall) begin
            tx_shift <= '0;
            cipo_oe  <= 1'b0;
        end else if (load_rd) begin
            tx_shift <= rd_val;
            cipo_oe  <= 1'b1;
        end else if (state == SHIFT && sclk_fall && cipo_oe && bit_cnt > CNT_HDR) begin
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end
    end

    assign cipo = cipo_oe & tx_shift[DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (do_write) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (f_addr == ADDR_W'(i)) mem[i] <= f_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= do_write;
            frame_err <= do_err;
            if (do_write) wr_addr <= f_addr;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule
